control_unit: RTL and testbench
===============================

# control_unit

Fetch/decode/execute controller for the 16-bit datapath. Holds the PC and instruction register, reads a synchronous instruction ROM, and drives every control input of the data-memory/register-file datapath stage directly downstream (data-memory address/write, register-file read/write addresses and write enable, write-data mux select, ALU function). It is a Moore FSM: all datapath controls are decoded from state and IR only.

## Interface
- PC_WIDTH, 7, program counter / instruction-ROM address width
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; forces INIT immediately
- I_data  input  16  instruction ROM read data, valid the cycle after I_rd is asserted
- PC_addr  output  PC_WIDTH  instruction ROM address (current PC)
- I_rd  output  1  instruction ROM read enable
- D_addr  output  8  data memory address
- D_wr  output  1  data memory write enable
- RF_s  output  1  register-file write-data select: 1 = data memory q, 0 = ALU result
- RF_W_en  output  1  register-file write enable
- RF_W_addr  output  5  register-file write address
- RF_Ra_addr  output  5  register-file read address A
- RF_Rb_addr  output  5  register-file read address B
- ALU_s0  output  3  ALU function: 0 pass A, 1 add, 2 subtract
- halted  output  1  high while in HALT
- state_out  output  4  current state encoding, for debug

## Operation
- Instruction format: opcode = IR[15:12]. Register fields are 4 bits, zero-extended to 5 bits (MSB of every RF address output is 0).
- NOOP 0000; STORE 0001: D_addr=IR[11:4], Ra=IR[3:0]; LOAD 0010: Rd=IR[11:8], D_addr=IR[7:0]; ADD 0011 / SUB 0100: Ra=IR[11:8], Rb=IR[7:4], Rd=IR[3:0]; HALT 0101; opcodes 0110-1111 decode as NOOP.
- States (state_out): INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8, HALT 9.
- INIT: PC <= 0, IR <= 0; -> FETCH.
- FETCH: I_rd=1, PC_addr=PC; PC <= PC+1 on exit; -> DECODE.
- DECODE: IR <= I_data on exit; next state from I_data[15:12].
- LOAD_A: D_addr=IR[7:0], D_wr=0 (read issued); -> LOAD_B.
- LOAD_B: D_addr=IR[7:0], RF_s=1, RF_W_en=1, RF_W_addr=IR[11:8]; -> FETCH.
- STORE: D_addr=IR[11:4], D_wr=1, RF_Ra_addr=IR[3:0]; -> FETCH.
- ADD / SUB: RF_Ra_addr, RF_Rb_addr, RF_W_addr from IR; RF_W_en=1, RF_s=0, ALU_s0=1 / 2; -> FETCH.
- NOOP: no controls; -> FETCH.
- HALT: halted=1, no controls, PC frozen; stays until reset.
- Any control not listed for a state is 0.

## Timing
- Reset values: state INIT, PC=0, IR=0, every output 0 except state_out=0. Because outputs are decoded from state, assertion of reset deasserts D_wr and RF_W_en in the same cycle (no write completes after a mid-instruction reset).
- Cycles per instruction from FETCH entry: NOOP/STORE/ADD/SUB/undefined 3, LOAD 4, HALT 2 then stalls.
- First FETCH is the second rising edge after reset release (one INIT cycle).
- PC arithmetic is modulo 2^PC_WIDTH: PC=127 (default) increments to 0, no flag.
- Writes (D_wr, RF_W_en) are high for exactly one cycle per STORE/LOAD/ADD/SUB; never high in FETCH, DECODE, NOOP, HALT, INIT.
- IR changes only on DECODE exit; execute-state outputs are stable for the whole state.

## Test plan
- Reset then ROM all zeros -> state cycles 0,1,2,3,1,2,3...; PC_addr 0,1,2 on successive FETCHes; D_wr and RF_W_en never asserted.
- ROM[0]=0x2A1B (LOAD R10,0x1B) -> LOAD_A: D_addr=0x1B, D_wr=0; LOAD_B: RF_s=1, RF_W_en=1, RF_W_addr=5'h0A; FETCH of PC=1 on 5th cycle after first FETCH.
- ROM[0]=0x3123 (ADD), ROM[1]=0x4456 (SUB), ROM[2]=0x1AB7 (STORE) -> ADD: Ra=1,Rb=2,Rd=3,ALU_s0=1,RF_W_en=1; SUB: Ra=4,Rb=5,Rd=6,ALU_s0=2; STORE: D_addr=0xAB, Ra=7, D_wr=1 one cycle.
- ROM[0]=0xF000, ROM[1]=0x5000 -> undefined opcode behaves as NOOP; then HALT: halted=1, state_out=9, PC_addr held at 2 for 20 cycles.
- Assert reset mid LOAD_B and mid STORE -> RF_W_en/D_wr drop in the same cycle, state_out=0, PC=0; normal fetch from 0 after release.
- ROM of 128 NOOPs -> PC_addr goes 127 then 0 on next FETCH, no hang.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute Moore controller for the 16-bit datapath.
// Holds the PC and the operand fields of the instruction register, drives the
// synchronous instruction ROM, and decodes every datapath control from state + IR.
module control_unit #(
    parameter int PC_WIDTH = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         I_data,
    output logic [PC_WIDTH-1:0] PC_addr,
    output logic                I_rd,
    output logic [7:0]          D_addr,
    output logic                D_wr,
    output logic                RF_s,
    output logic                RF_W_en,
    output logic [4:0]          RF_W_addr,
    output logic [4:0]          RF_Ra_addr,
    output logic [4:0]          RF_Rb_addr,
    output logic [2:0]          ALU_s0,
    output logic                halted,
    output logic [3:0]          state_out
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    state_t              state;
    state_t              next_state;
    logic [PC_WIDTH-1:0] pc;
    // Only the operand bits of the instruction are kept: the opcode is already
    // captured by the execute state chosen on DECODE exit.
    logic [11:0]         ir;

    // Map an opcode to its first execute state; unused opcodes fall back to NOOP.
    function automatic state_t decode_op(input logic [3:0] op);
        case (op)
            OP_NOOP:  return S_NOOP;
            OP_STORE: return S_STORE;
            OP_LOAD:  return S_LOAD_A;
            OP_ADD:   return S_ADD;
            OP_SUB:   return S_SUB;
            OP_HALT:  return S_HALT;
            default:  return S_NOOP;
        endcase
    endfunction

    // State register; reset forces INIT immediately so writes drop at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_INIT;
        end else begin
            state <= next_state;
        end
    end

    // PC and IR: PC advances on FETCH exit (wrapping), IR loads on DECODE exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
            ir <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    pc <= '0;
                    ir <= '0;
                end
                S_FETCH:  pc <= pc + PC_WIDTH'(1);
                S_DECODE: ir <= I_data[11:0];
                default: ;
            endcase
        end
    end

    // Next-state logic and Moore output decode from state and IR.
    always_comb begin
        next_state = state;
        PC_addr    = pc;
        I_rd       = 1'b0;
        D_addr     = 8'h00;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_en    = 1'b0;
        RF_W_addr  = 5'h00;
        RF_Ra_addr = 5'h00;
        RF_Rb_addr = 5'h00;
        ALU_s0     = ALU_PASS;
        halted     = 1'b0;
        state_out  = state;

        case (state)
            S_INIT: next_state = S_FETCH;
            S_FETCH: begin
                I_rd       = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: next_state = decode_op(I_data[15:12]);
            S_NOOP:   next_state = S_FETCH;
            S_LOAD_A: begin
                // Read is issued here; the data memory returns q in LOAD_B.
                D_addr     = ir[7:0];
                next_state = S_LOAD_B;
            end
            S_LOAD_B: begin
                D_addr     = ir[7:0];
                RF_s       = 1'b1;
                RF_W_en    = 1'b1;
                RF_W_addr  = {1'b0, ir[11:8]};
                next_state = S_FETCH;
            end
            S_STORE: begin
                D_addr     = ir[11:4];
                D_wr       = 1'b1;
                RF_Ra_addr = {1'b0, ir[3:0]};
                next_state = S_FETCH;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = {1'b0, ir[11:8]};
                RF_Rb_addr = {1'b0, ir[7:4]};
                RF_W_addr  = {1'b0, ir[3:0]};
                RF_W_en    = 1'b1;
                ALU_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
                next_state = S_FETCH;
            end
            S_HALT: begin
                halted     = 1'b1;
                next_state = S_HALT;
            end
            default: next_state = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector bench for control_unit with a synchronous ROM model.
module tb_control_unit;

    localparam int PC_WIDTH = 7;

    logic                clk;
    logic                reset;
    logic [15:0]         I_data;
    logic [PC_WIDTH-1:0] PC_addr;
    logic                I_rd;
    logic [7:0]          D_addr;
    logic                D_wr;
    logic                RF_s;
    logic                RF_W_en;
    logic [4:0]          RF_W_addr;
    logic [4:0]          RF_Ra_addr;
    logic [4:0]          RF_Rb_addr;
    logic [2:0]          ALU_s0;
    logic                halted;
    logic [3:0]          state_out;

    logic [15:0] rom [0:127];
    int n_cmp = 0;
    int n_err = 0;

    control_unit #(.PC_WIDTH(PC_WIDTH)) dut (
        .clk(clk), .reset(reset), .I_data(I_data),
        .PC_addr(PC_addr), .I_rd(I_rd), .D_addr(D_addr), .D_wr(D_wr),
        .RF_s(RF_s), .RF_W_en(RF_W_en), .RF_W_addr(RF_W_addr),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .ALU_s0(ALU_s0),
        .halted(halted), .state_out(state_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction ROM: data appears the cycle after I_rd.
    always @(posedge clk or posedge reset) begin
        if (reset) I_data <= 16'h0000;
        else if (I_rd) I_data <= rom[PC_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("init_state", state_out, 0);
    endtask

    initial begin
        int fetches;
        reset = 1'b1;
        clear_rom();
        @(negedge clk);
        @(negedge clk);

        // Reset state: everything zero.
        check_eq("rst_state", state_out, 0);
        check_eq("rst_pc", PC_addr, 0);
        check_eq("rst_ctrl", {I_rd, D_addr, D_wr, RF_s, RF_W_en, RF_W_addr,
                              RF_Ra_addr, RF_Rb_addr, ALU_s0, halted}, 0);

        // All-NOOP ROM: state 1,2,3 repeating, PC advancing, no writes.
        reset = 1'b0;
        check_eq("init_state", state_out, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("nop_fetch_state", state_out, 1);
            check_eq("nop_fetch_pc", PC_addr, k);
            check_eq("nop_fetch_ird", I_rd, 1);
            step();
            check_eq("nop_decode_state", state_out, 2);
            check_eq("nop_decode_ird", I_rd, 0);
            step();
            check_eq("nop_exec_state", state_out, 3);
            check_eq("nop_writes", {D_wr, RF_W_en}, 0);
        end

        // LOAD R10, 0x1B
        clear_rom();
        rom[0] = 16'h2A1B;
        do_reset();
        step(); check_eq("ld_fetch", state_out, 1);
        step(); check_eq("ld_decode", state_out, 2);
        step();
        check_eq("ld_a_state", state_out, 4);
        check_eq("ld_a_daddr", D_addr, 8'h1B);
        check_eq("ld_a_dwr", D_wr, 0);
        check_eq("ld_a_wen", RF_W_en, 0);
        step();
        check_eq("ld_b_state", state_out, 5);
        check_eq("ld_b_daddr", D_addr, 8'h1B);
        check_eq("ld_b_rfs", RF_s, 1);
        check_eq("ld_b_wen", RF_W_en, 1);
        check_eq("ld_b_waddr", RF_W_addr, 5'h0A);
        step();
        check_eq("ld_next_fetch", state_out, 1);
        check_eq("ld_next_pc", PC_addr, 1);
        check_eq("ld_next_wen", RF_W_en, 0);

        // ADD, SUB, STORE sequence
        clear_rom();
        rom[0] = 16'h3123;
        rom[1] = 16'h4456;
        rom[2] = 16'h1AB7;
        do_reset();
        step(); step(); step();
        check_eq("add_state", state_out, 7);
        check_eq("add_regs", {RF_Ra_addr, RF_Rb_addr, RF_W_addr}, {5'd1, 5'd2, 5'd3});
        check_eq("add_alu", ALU_s0, 1);
        check_eq("add_wen_rfs", {RF_W_en, RF_s}, 2'b10);
        step(); step(); step();
        check_eq("sub_state", state_out, 8);
        check_eq("sub_regs", {RF_Ra_addr, RF_Rb_addr, RF_W_addr}, {5'd4, 5'd5, 5'd6});
        check_eq("sub_alu", ALU_s0, 2);
        check_eq("sub_wen", RF_W_en, 1);
        step(); step(); step();
        check_eq("st_state", state_out, 6);
        check_eq("st_daddr", D_addr, 8'hAB);
        check_eq("st_ra", RF_Ra_addr, 5'd7);
        check_eq("st_dwr", D_wr, 1);
        check_eq("st_wen", RF_W_en, 0);
        step();
        check_eq("st_after_dwr", D_wr, 0);
        check_eq("st_after_state", state_out, 1);

        // Undefined opcode then HALT
        clear_rom();
        rom[0] = 16'hF000;
        rom[1] = 16'h5000;
        do_reset();
        step(); step(); step();
        check_eq("undef_as_noop", state_out, 3);
        check_eq("undef_writes", {D_wr, RF_W_en}, 0);
        step(); step(); step();
        for (int k = 0; k < 20; k++) begin
            check_eq("halt_state", state_out, 9);
            check_eq("halt_flag", halted, 1);
            check_eq("halt_pc", PC_addr, 2);
            check_eq("halt_ird", I_rd, 0);
            step();
        end

        // Reset asserted in the middle of LOAD_B
        clear_rom();
        rom[0] = 16'h2A1B;
        do_reset();
        step(); step(); step(); step();
        check_eq("mid_ld_wen_pre", RF_W_en, 1);
        reset = 1'b1;
        #1;
        check_eq("mid_ld_wen", RF_W_en, 0);
        check_eq("mid_ld_state", state_out, 0);
        check_eq("mid_ld_pc", PC_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_eq("mid_ld_refetch", state_out, 1);
        check_eq("mid_ld_refetch_pc", PC_addr, 0);

        // Reset asserted in the middle of STORE
        clear_rom();
        rom[0] = 16'h1AB7;
        do_reset();
        step(); step(); step();
        check_eq("mid_st_dwr_pre", D_wr, 1);
        reset = 1'b1;
        #1;
        check_eq("mid_st_dwr", D_wr, 0);
        check_eq("mid_st_state", state_out, 0);
        check_eq("mid_st_pc", PC_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_eq("mid_st_refetch", state_out, 1);
        check_eq("mid_st_refetch_pc", PC_addr, 0);

        // PC wrap with 128+ NOOPs
        clear_rom();
        do_reset();
        fetches = 0;
        for (int cyc = 0; cyc < 500 && fetches < 130; cyc++) begin
            step();
            if (state_out == 4'd1) begin
                check_eq("wrap_pc", PC_addr, fetches % 128);
                fetches++;
            end
        end
        check_eq("wrap_done", fetches, 130);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
